// File: rtl/mac_lane_array.sv
// mac_lane_array: multi-lane signed multiply-accumulate engine.
// Beats flow through three registered stages: per-lane products, an adder
// tree reduction, and an accumulator that closes a dot product on a
// last-flagged beat. The whole pipeline freezes while a finished result waits
// for the consumer.
//
// Handshake: a beat moves on any rising edge where in_valid & in_ready. A
// result moves on any rising edge where out_valid & out_ready. out_valid,
// out_data and out_ovf stay constant while out_valid & ~out_ready. in_ready
// is combinational and low during a stall or a flush.
module mac_lane_array #(
  parameter int LANES  = 4,
  parameter int DATA_W = 8,
  parameter int ACC_W  = 26,
  parameter int SAT    = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      relu,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      in_last,
  input  logic [LANES-1:0]          in_mask,
  input  logic [LANES*DATA_W-1:0]   in_act,
  input  logic [LANES*DATA_W-1:0]   in_wgt,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [ACC_W-1:0]          out_data,
  output logic                      out_ovf
);

  localparam int PROD_W = 2 * DATA_W;
  localparam int SUM_W  = PROD_W + $clog2(LANES);

  logic                         stall;
  logic                         accept;

  // Stage 1: per-lane products
  logic                         s1_valid_q;
  logic                         s1_last_q;
  logic [LANES-1:0][PROD_W-1:0] prod_q;
  logic [LANES-1:0][PROD_W-1:0] prod_d;

  // Stage 2: reduced sum
  logic                         s2_valid_q;
  logic                         s2_last_q;
  logic signed [SUM_W-1:0]      sum_q;
  logic signed [SUM_W-1:0]      sum_d;

  // Stage 3: accumulator and result
  logic signed [ACC_W-1:0]      acc_q;
  logic signed [ACC_W-1:0]      acc_d;
  logic signed [ACC_W-1:0]      res_d;
  logic signed [ACC_W:0]        acc_wide;
  logic                         step_ovf;
  logic                         ovf_q;
  logic                         out_valid_q;
  logic [ACC_W-1:0]             out_data_q;
  logic                         out_ovf_q;

  assign stall    = out_valid_q & ~out_ready;
  assign in_ready = ~stall & ~flush;
  assign accept   = in_valid & in_ready;

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ovf   = out_ovf_q;

  // Signed lane products; masked lanes contribute zero.
  always_comb begin
    prod_d = '0;
    for (int i = 0; i < LANES; i++) begin
      if (in_mask[i]) begin
        prod_d[i] = PROD_W'($signed(in_act[i*DATA_W +: DATA_W]))
                  * PROD_W'($signed(in_wgt[i*DATA_W +: DATA_W]));
      end
    end
  end

  // Sign-extended reduction of all registered lane products.
  always_comb begin
    sum_d = '0;
    for (int i = 0; i < LANES; i++) begin
      sum_d = sum_d + SUM_W'($signed(prod_q[i]));
    end
  end

  // Accumulate one guard bit wide, detect range exit, then clamp or wrap and apply ReLU.
  always_comb begin
    acc_wide = (ACC_W+1)'(acc_q) + (ACC_W+1)'(sum_q);
    step_ovf = acc_wide[ACC_W] ^ acc_wide[ACC_W-1];
    acc_d    = acc_wide[ACC_W-1:0];
    if (step_ovf && (SAT != 0)) begin
      acc_d = acc_wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                              : {1'b0, {(ACC_W-1){1'b1}}};
    end
    res_d = (relu && acc_d[ACC_W-1]) ? '0 : acc_d;
  end

  // Pipeline, accumulator and output registers; flush beats everything, a stall holds everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      prod_q      <= '0;
      s2_valid_q  <= 1'b0;
      s2_last_q   <= 1'b0;
      sum_q       <= '0;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ovf_q   <= 1'b0;
    end else if (flush) begin
      s1_valid_q  <= 1'b0;
      s2_valid_q  <= 1'b0;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ovf_q   <= 1'b0;
    end else if (!stall) begin
      s1_valid_q <= accept;
      if (accept) begin
        s1_last_q <= in_last;
        prod_q    <= prod_d;
      end
      s2_valid_q <= s1_valid_q;
      s2_last_q  <= s1_last_q;
      sum_q      <= sum_d;
      if (s2_valid_q) begin
        if (s2_last_q) begin
          acc_q      <= '0;
          ovf_q      <= 1'b0;
          out_data_q <= res_d;
          out_ovf_q  <= ovf_q | step_ovf;
        end else begin
          acc_q <= acc_d;
          ovf_q <= ovf_q | step_ovf;
        end
      end
      // Not stalled means any pending result is being taken this edge.
      out_valid_q <= s2_valid_q & s2_last_q;
    end
  end

endmodule

// File: tb/tb_mac_lane_array.sv
// Testbench for mac_lane_array: a saturating and a wrapping instance share
// one stimulus stream; a reference model pushes expected results into
// per-instance queues and a monitor pops them as results are handed over.
module tb_mac_lane_array;

  localparam int     LANES   = 4;
  localparam int     DATA_W  = 8;
  localparam int     ACC_W   = 20;
  localparam longint ACC_MAX = (longint'(1) << (ACC_W - 1)) - 1;
  localparam longint ACC_MIN = -(longint'(1) << (ACC_W - 1));

  // ---------------- clock / reset / signals ----------------
  logic                    clk = 1'b0;
  logic                    rst;
  logic                    flush;
  logic                    relu;
  logic                    in_valid;
  logic                    in_last;
  logic [LANES-1:0]        in_mask;
  logic [LANES*DATA_W-1:0] in_act;
  logic [LANES*DATA_W-1:0] in_wgt;
  logic                    out_ready;

  logic                    in_ready_s, out_valid_s, out_ovf_s;
  logic [ACC_W-1:0]        out_data_s;
  logic                    in_ready_w, out_valid_w, out_ovf_w;
  logic [ACC_W-1:0]        out_data_w;

  always #5 clk = ~clk;

  mac_lane_array #(.LANES(LANES), .DATA_W(DATA_W), .ACC_W(ACC_W), .SAT(1)) u_sat (
    .clk(clk), .rst(rst), .flush(flush), .relu(relu),
    .in_valid(in_valid), .in_ready(in_ready_s), .in_last(in_last),
    .in_mask(in_mask), .in_act(in_act), .in_wgt(in_wgt),
    .out_valid(out_valid_s), .out_ready(out_ready),
    .out_data(out_data_s), .out_ovf(out_ovf_s)
  );

  mac_lane_array #(.LANES(LANES), .DATA_W(DATA_W), .ACC_W(ACC_W), .SAT(0)) u_wrap (
    .clk(clk), .rst(rst), .flush(flush), .relu(relu),
    .in_valid(in_valid), .in_ready(in_ready_w), .in_last(in_last),
    .in_mask(in_mask), .in_act(in_act), .in_wgt(in_wgt),
    .out_valid(out_valid_w), .out_ready(out_ready),
    .out_data(out_data_w), .out_ovf(out_ovf_w)
  );

  // ---------------- scoreboard state ----------------
  int               errors = 0;
  int               checks = 0;
  bit               rand_rdy = 1'b0;
  logic [ACC_W:0]   exp_s[$];   // {ovf, data} for the saturating instance
  logic [ACC_W:0]   exp_w[$];   // {ovf, data} for the wrapping instance
  longint           m_acc[2];   // index 0 = saturating, 1 = wrapping
  bit               m_ovf[2];

  task automatic check(input string name, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic summary();
    $display("Result: errors=%0d of %0d checks", errors, checks);
  endtask

  function automatic logic [31:0] pack4(input int a0, input int a1, input int a2, input int a3);
    logic [31:0] p;
    p[7:0]   = a0[7:0];
    p[15:8]  = a1[7:0];
    p[23:16] = a2[7:0];
    p[31:24] = a3[7:0];
    return p;
  endfunction

  task automatic model_reset();
    m_acc[0] = 0; m_acc[1] = 0;
    m_ovf[0] = 1'b0; m_ovf[1] = 1'b0;
  endtask

  // Reference: dot product with plain integer arithmetic, then range handling.
  task automatic model_beat(input logic [31:0] act, input logic [31:0] wgt,
                            input logic [3:0] mask, input logic last);
    longint         sum = 0;
    longint         t;
    longint         r;
    bit             ov;
    logic [ACC_W:0] v;
    for (int l = 0; l < LANES; l++) begin
      if (mask[l]) sum += longint'($signed(act[l*8 +: 8])) * longint'($signed(wgt[l*8 +: 8]));
    end
    for (int k = 0; k < 2; k++) begin
      t  = m_acc[k] + sum;
      ov = (t > ACC_MAX) || (t < ACC_MIN);
      if (ov) begin
        if (k == 0) t = (t > ACC_MAX) ? ACC_MAX : ACC_MIN;
        else begin
          t = t & ((longint'(1) << ACC_W) - 1);
          if (t > ACC_MAX) t -= (longint'(1) << ACC_W);
        end
      end
      m_ovf[k] = m_ovf[k] | ov;
      if (last) begin
        r = (relu && t < 0) ? 0 : t;
        v = {m_ovf[k], r[ACC_W-1:0]};
        if (k == 0) exp_s.push_back(v);
        else        exp_w.push_back(v);
        m_acc[k] = 0;
        m_ovf[k] = 1'b0;
      end else begin
        m_acc[k] = t;
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic send_beat(input logic [31:0] act, input logic [31:0] wgt,
                           input logic [3:0] mask, input logic last);
    bit accepted = 1'b0;
    int cnt = 0;
    in_valid = 1'b1;
    in_act   = act;
    in_wgt   = wgt;
    in_mask  = mask;
    in_last  = last;
    while (!accepted) begin
      @(negedge clk);
      if (in_ready_s) begin
        accepted = 1'b1;
        model_beat(act, wgt, mask, last);
      end
      @(posedge clk);
      #1;
      cnt++;
      if (!accepted && cnt > 500) begin
        errors++;
        checks++;
        $display("FAIL accept_timeout: got no acceptance expected acceptance within 500 cycles");
        summary();
        $fatal(1, "beat never accepted");
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_empty();
    int cnt = 0;
    while (exp_s.size() != 0 || exp_w.size() != 0) begin
      @(negedge clk);
      cnt++;
      if (cnt > 300) begin
        errors++;
        checks++;
        $display("FAIL drain_timeout: got %0d pending results expected 0", exp_s.size() + exp_w.size());
        exp_s.delete();
        exp_w.delete();
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Random consumer backpressure when enabled.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // ---------------- monitor ----------------
  logic [ACC_W:0] e;
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid_s && out_ready) begin
        if (exp_s.size() == 0) begin
          errors++;
          checks++;
          $display("FAIL sat_unexpected: got output %0d expected none", $signed(out_data_s));
        end else begin
          e = exp_s.pop_front();
          check("sat_data", $signed(out_data_s), $signed(e[ACC_W-1:0]));
          check("sat_ovf", out_ovf_s, e[ACC_W]);
        end
      end
      if (out_valid_w && out_ready) begin
        if (exp_w.size() == 0) begin
          errors++;
          checks++;
          $display("FAIL wrap_unexpected: got output %0d expected none", $signed(out_data_w));
        end else begin
          e = exp_w.pop_front();
          check("wrap_data", $signed(out_data_w), $signed(e[ACC_W-1:0]));
          check("wrap_ovf", out_ovf_w, e[ACC_W]);
        end
      end
    end
  end

  // Watchdog.
  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog: got no end of test expected finish before 500000 time units");
    summary();
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b1; flush = 1'b0; relu = 1'b0;
    in_valid = 1'b0; in_last = 1'b0; in_mask = '0; in_act = '0; in_wgt = '0;
    out_ready = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", in_ready_s, 1);
    check("rst_out_valid", out_valid_s, 0);
    check("rst_out_data", out_data_s, 0);
    check("rst_out_ovf", out_ovf_s, 0);
    check("rst_out_valid_w", out_valid_w, 0);
    @(posedge clk);
    #1;

    // Single beat, 70, result visible exactly in cycle 3 for one cycle.
    send_beat(pack4(1, 2, 3, 4), pack4(5, 6, 7, 8), 4'hF, 1'b1);
    @(negedge clk); check("lat_edge1", out_valid_s, 0);
    @(negedge clk); check("lat_edge2", out_valid_s, 0);
    @(negedge clk); check("lat_edge3", out_valid_s, 1);
    @(negedge clk); check("lat_edge4", out_valid_s, 0);
    wait_empty();

    // Signed extremes with lane 3 masked: 16257.
    send_beat(pack4(-128, -128, 127, 10), pack4(-128, 127, 127, 10), 4'b0111, 1'b1);

    // Back-to-back vectors: 12, -8, 0.
    send_beat(pack4(1, 1, 1, 1), pack4(1, 1, 1, 1), 4'hF, 1'b0);
    send_beat(pack4(1, 1, 1, 1), pack4(1, 1, 1, 1), 4'hF, 1'b0);
    send_beat(pack4(1, 1, 1, 1), pack4(1, 1, 1, 1), 4'hF, 1'b1);
    send_beat(pack4(2, 2, 2, 2), pack4(-1, -1, -1, -1), 4'hF, 1'b1);
    send_beat($urandom(), $urandom(), 4'h0, 1'b1);
    wait_empty();

    // ReLU on a negative result.
    relu = 1'b1;
    send_beat(pack4(2, 2, 2, 2), pack4(-1, -1, -1, -1), 4'hF, 1'b1);
    wait_empty();
    relu = 1'b0;

    // Overflow: nine beats of 4*127*127, then a clean vector.
    for (int b = 0; b < 9; b++)
      send_beat(pack4(127, 127, 127, 127), pack4(127, 127, 127, 127), 4'hF, b == 8);
    send_beat(pack4(3, 0, 0, 0), pack4(-5, 0, 0, 0), 4'hF, 1'b1);
    wait_empty();

    // Backpressure: hold a result (100) for 5 cycles while the source streams.
    out_ready = 1'b0;
    send_beat(pack4(5, 5, 5, 5), pack4(5, 5, 5, 5), 4'hF, 1'b1);
    begin
      int cnt = 0;
      while (!out_valid_s && cnt < 10) begin
        @(negedge clk);
        cnt++;
      end
      check("bp_result_arrives", out_valid_s, 1);
    end
    fork
      begin
        for (int v = 0; v < 3; v++)
          send_beat($urandom(), $urandom(), 4'($urandom_range(0, 15)), 1'b1);
      end
      begin
        repeat (5) begin
          check("bp_in_ready", in_ready_s, 0);
          check("bp_out_valid", out_valid_s, 1);
          check("bp_out_data", $signed(out_data_s), 100);
          @(negedge clk);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    wait_empty();

    // Flush after 2 of 3 beats, then an uncontaminated vector (10).
    send_beat(pack4(50, 50, 50, 50), pack4(50, 50, 50, 50), 4'hF, 1'b0);
    send_beat(pack4(50, 50, 50, 50), pack4(50, 50, 50, 50), 4'hF, 1'b0);
    flush = 1'b1;
    in_valid = 1'b1;
    @(negedge clk);
    check("flush_in_ready", in_ready_s, 0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    in_valid = 1'b0;
    model_reset();
    send_beat(pack4(1, 2, 3, 4), pack4(1, 1, 1, 1), 4'hF, 1'b1);
    wait_empty();

    // Asynchronous reset mid-vector with a result pending.
    out_ready = 1'b0;
    send_beat(pack4(3, 3, 3, 3), pack4(3, 3, 3, 3), 4'hF, 1'b1);
    send_beat(pack4(9, 9, 9, 9), pack4(9, 9, 9, 9), 4'hF, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("arst_in_ready", in_ready_s, 1);
    check("arst_out_valid", out_valid_s, 0);
    check("arst_out_data", out_data_s, 0);
    check("arst_out_ovf", out_ovf_s, 0);
    check("arst_out_valid_w", out_valid_w, 0);
    exp_s.delete();
    exp_w.delete();
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    out_ready = 1'b1;
    send_beat(pack4(1, 1, 1, 1), pack4(1, 1, 1, 1), 4'hF, 1'b1);
    wait_empty();

    // Randomized vectors with random backpressure and idle gaps.
    for (int blk = 0; blk < 5; blk++) begin
      relu = 1'($urandom_range(0, 1));
      rand_rdy = 1'b1;
      for (int v = 0; v < 6; v++) begin
        int nb;
        nb = $urandom_range(1, 4 + 4 * (blk % 2));
        for (int b = 0; b < nb; b++) begin
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
          end
          send_beat($urandom(), $urandom(), 4'($urandom_range(0, 15)), b == nb - 1);
        end
      end
      wait_empty();
      rand_rdy = 1'b0;
      out_ready = 1'b1;
      wait_empty();
    end

    summary();
    $finish;
  end

endmodule

// File: doc/mac_lane_array.md
# mac_lane_array

Parametrised multi-lane signed multiply-accumulate engine with a streaming valid/ready interface. Each accepted beat carries LANES packed activation/weight pairs with a per-lane mask. The block multiplies and reduces the active lanes through a registered adder tree, then accumulates beats until a last-flagged beat closes the dot product. It is the successor to the fixed 4-lane MAC controller in the MNIST datapath, adding configurable lane count and widths, backpressure, optional saturation with overflow reporting, and an optional ReLU on the output.

## Interface
- LANES, 4, number of parallel multiply lanes (>=1)
- DATA_W, 8, signed width of each activation and weight element
- ACC_W, 26, signed accumulator/output width; must be >= 2*DATA_W + clog2(LANES)
- SAT, 0, 1 = clamp accumulator at each step, 0 = wrap modulo 2^ACC_W

- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- flush  in  1  synchronous abort: clears pipeline, accumulator, overflow flag and output
- relu  in  1  quasi-static; 1 = negative results output as 0; must be stable for the duration of a vector
- in_valid  in  1  beat present
- in_ready  out  1  beat accepted when in_valid & in_ready
- in_last  in  1  beat closes the current vector
- in_mask  in  LANES  lane i contributes only if in_mask[i]=1
- in_act  in  LANES*DATA_W  lane i at [i*DATA_W +: DATA_W], signed
- in_wgt  in  LANES*DATA_W  same packing, signed
- out_valid  out  1  result held until out_ready
- out_ready  in  1  consumer accepts result
- out_data  out  ACC_W  signed dot product (post saturation/ReLU)
- out_ovf  out  1  1 = accumulation left the ACC_W range at least once in this vector

## Operation
- Stage 1 (product): on accept, register p_i = in_act_i * in_wgt_i (signed, 2*DATA_W bits) or 0 if masked; register valid and last.
- Stage 2 (reduce): register the sign-extended sum of all p_i (2*DATA_W + clog2(LANES) bits).
- Stage 3 (accumulate): acc_next = acc + sum, computed at ACC_W+1 bits. If it is out of signed ACC_W range, set the sticky ovf flag. With SAT=1, clamp to [-2^(ACC_W-1), 2^(ACC_W-1)-1]; with SAT=0, truncate.
- On a stage-3 beat with last=1: load out_data = relu ? max(acc_next,0) : acc_next; set out_ovf = ovf | this-step overflow; assert out_valid; clear acc and ovf to 0 on the same edge. Consecutive vectors need no idle cycle.
- A beat with in_mask = 0 is legal. It contributes 0, and its in_last is honoured.
- Global stall: stall = out_valid & ~out_ready. While stalled, every stage register, acc and out_* hold.
- in_ready = ~stall & ~flush (combinational).
- out_valid clears on the edge where out_valid & out_ready, unless a new result loads on that same edge.
- Flush has priority over all other activity. On that edge, stage valids, acc, ovf, out_valid and out_ovf go to 0, and out_data goes to 0. No beat is accepted in the flush cycle.
- Reset (async, any time, including mid-vector): all registers go to 0. in_ready reads 1 after release.

## Timing
- Reset values: in_ready=1 (combinational), out_valid=0, out_data=0, out_ovf=0. Internal acc, ovf and stage valids are 0.
- Latency: a last beat accepted in cycle 0 gives out_valid=1 in cycle 3 (three rising edges), absent stalls.
- Throughput: one beat per cycle while out_ready=1 or no result is pending.
- Stall cycles add one-for-one to latency. No beat is dropped or duplicated.
- out_data and out_ovf are stable while out_valid=1 and out_ready=0.
- in_ready may drop in the same cycle out_valid rises. A source must hold in_valid and data until accepted.

## Test plan
- Single beat, LANES=4, act={1,2,3,4}, wgt={5,6,7,8}, mask=4'hF, last=1, out_ready=1 -> out_data=70, out_ovf=0, out_valid exactly one cycle, in cycle 3.
- Signed extremes with mask: act={-128,-128,127,10}, wgt={-128,127,127,10}, mask=4'b0111 -> out_data=16257 (lane 3 ignored).
- Back-to-back vectors: three beats all act=1,wgt=1 (last on third), then one beat act=2,wgt=-1 last, then one beat mask=0 last -> outputs 12, -8, 0 in order with no idle cycles.
- Backpressure: hold out_ready=0 for 5 cycles with a result pending while the source streams beats -> in_ready=0, out_data frozen, no loss; after release all subsequent results are correct.
- Overflow, ACC_W=20, LANES=4: nine beats all act=127,wgt=127 -> SAT=1 gives out_data=524287, out_ovf=1; SAT=0 gives out_data=-467932, out_ovf=1; the next vector starts with out_ovf=0.
- ReLU/flush/reset: a vector summing to -8 with relu=1 -> out_data=0. Assert flush after 2 of 3 beats -> no output, and the next vector's result is uncontaminated. Assert rst mid-vector -> all outputs return to reset values immediately.
